lcd_text_composer: RTL and testbench

- Sequential successor to the combinational LCD character generator. Builds a ROWS x COLS character frame.
- Row 0 shows the display-mode banner. Row 1 shows a labelled unsigned value, converted to decimal by a multi-cycle double-dabble engine.
- Sits between the mode/statistics logic and the LCD controller. Uses a valid/ready request handshake and a registered frame output.

---
 rtl/lcd_text_composer.sv | 147 ++++++++++++++
 tb/tb_lcd_text_composer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_composer.sv
// lcd_text_composer: registered ROWS x COLS LCD frame with a mode banner on row 0 and a
// serially converted (double-dabble) decimal value on row 1. Macro LCD_SCROLL_EN adds row-0 scrolling.
module lcd_text_composer #(
  parameter int          COLS       = 16,
  parameter int          ROWS       = 2,
  parameter int          VAL_W      = 16,
  parameter int          DIGITS     = 5,
  parameter logic [7:0]  BLANK      = 8'h10,
  parameter logic [23:0] SCROLL_DIV = 24'd12_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [7:0]             i_mode,
  input  logic [VAL_W-1:0]       i_value,
  output logic [ROWS*COLS*8-1:0] o_string,
  output logic                   o_done
);
  localparam int FW = ROWS * COLS * 8;
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t           state;
  logic [7:0]       mode_q;
  logic [VAL_W-1:0] shift_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic [FW-1:0]    frame_q;
  logic [FW-1:0]    next_frame;
  logic             lead;
  logic [3:0]       dig;

  // Banner text is stored right-aligned in a 128-bit literal, first character highest.
  function automatic logic [7:0] banner_char(input logic [7:0] mode, input int c);
    logic [127:0] txt;
    int           len;
    case (mode)
      8'h00:   begin txt = "Original Picture"; len = 16; end
      8'h01:   begin txt = "Transmission Map"; len = 16; end
      8'h02:   begin txt = "Dehazed Picture";  len = 15; end
      8'hFF:   begin txt = '0;                 len = 0;  end
      default: begin txt = "I love DCLab!";    len = 13; end
    endcase
    if (c < len) return txt[(len-1-c)*8 +: 8];
    else         return BLANK;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    next_frame = {(ROWS*COLS){BLANK}};
    lead       = 1'b1;
    dig        = 4'd0;
    for (int c = 0; c < COLS; c++) next_frame[c*8 +: 8] = banner_char(mode_q, c);
    next_frame[(COLS+0)*8 +: 8] = 8'h56;
    next_frame[(COLS+1)*8 +: 8] = 8'h61;
    next_frame[(COLS+2)*8 +: 8] = 8'h6C;
    next_frame[(COLS+3)*8 +: 8] = 8'h3A;
    // Walk digits from most significant down; the units digit is always shown.
    for (int d = DIGITS-1; d >= 0; d--) begin
      dig = bcd_q[d*4 +: 4];
      if (dig != 4'd0 || d == 0) lead = 1'b0;
      if (!lead) next_frame[(2*COLS-1-d)*8 +: 8] = 8'h30 + {4'h0, dig};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_done  <= 1'b0;
      mode_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      frame_q <= {(ROWS*COLS){BLANK}};
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            mode_q  <= i_mode;
            shift_q <= i_value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            o_ready <= 1'b0;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q   <= {bcd_adj[BW-2:0], shift_q[VAL_W-1]};
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(VAL_W-1)) state <= FORMAT;
        end
        FORMAT: begin
          frame_q <= next_frame;
          o_done  <= 1'b1;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LCD_SCROLL_EN
  localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [23:0]   div_q;
  logic [OW-1:0] offset_q;

  // A fresh frame always starts unrotated with a full scroll period ahead.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q    <= '0;
      offset_q <= '0;
    end else if (state == FORMAT) begin
      div_q    <= '0;
      offset_q <= '0;
    end else if (div_q == SCROLL_DIV - 24'd1) begin
      div_q    <= '0;
      offset_q <= (offset_q == OW'(COLS-1)) ? '0 : offset_q + 1'b1;
    end else begin
      div_q <= div_q + 24'd1;
    end
  end

  always_comb begin
    o_string = frame_q;
    for (int c = 0; c < COLS; c++)
      o_string[c*8 +: 8] = frame_q[((c + int'(offset_q)) % COLS)*8 +: 8];
  end
`else
  assign o_string = frame_q;
`endif

endmodule

// File: tb/tb_lcd_text_composer.sv
// Self-checking bench for lcd_text_composer: directed table, back-to-back and reset-abort
// sequences, then randomized requests checked against a string-based reference model.
`timescale 1ns/1ps
module tb_lcd_text_composer;
  localparam int         COLS   = 16;
  localparam int         ROWS   = 2;
  localparam int         VAL_W  = 16;
  localparam int         DIGITS = 5;
  localparam int         FW     = ROWS * COLS * 8;
  localparam int         LAT    = VAL_W + 2;
  localparam logic [7:0] BLANK  = 8'h10;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             ready;
  logic             done;
  logic [7:0]       mode;
  logic [VAL_W-1:0] value;
  logic [FW-1:0]    frame;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0]       mode;
    logic [VAL_W-1:0] value;
    string            row0;
    string            row1;
  } vec_t;

  vec_t vecs[6];

  lcd_text_composer #(
    .COLS(COLS), .ROWS(ROWS), .VAL_W(VAL_W), .DIGITS(DIGITS),
    .BLANK(BLANK), .SCROLL_DIV(24'd4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_mode(mode), .i_value(value), .o_string(frame), .o_done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  // Underscore marks a BLANK cell; text shorter than COLS is padded with BLANK.
  function automatic logic [COLS*8-1:0] row_from_text(input string s);
    logic [COLS*8-1:0] r;
    for (int c = 0; c < COLS; c++) begin
      r[c*8 +: 8] = BLANK;
      if (c < s.len() && s[c] != 8'h5F) r[c*8 +: 8] = s[c];
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] model_frame(input logic [7:0] m, input logic [VAL_W-1:0] v);
    string         ban;
    string         num;
    string         line;
    logic [FW-1:0] f;
    case (m)
      8'h00:   ban = "Original Picture";
      8'h01:   ban = "Transmission Map";
      8'h02:   ban = "Dehazed Picture";
      8'hFF:   ban = "";
      default: ban = "I love DCLab!";
    endcase
    num  = $sformatf("%0d", v);
    line = "Val:";
    while (line.len() < COLS - num.len()) line = {line, "_"};
    line = {line, num};
    f = {(ROWS*COLS){BLANK}};
    f[0 +: COLS*8]    = row_from_text(ban);
    f[COLS*8 +: COLS*8] = row_from_text(line);
    return f;
  endfunction

  // Issues one request from a negedge, returns latency (cycles from accept to done) and the frame at done.
  task automatic apply_stimulus(input logic [7:0] m, input logic [VAL_W-1:0] v,
                                output int lat, output logic [FW-1:0] got);
    int guard;
    bit ready_ok;
    guard = 0;
    while (ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("ready before request", FW'(ready), FW'(1));
    mode  = m;
    value = v;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid    = 1'b0;
    mode     = 8'($urandom);
    value    = VAL_W'($urandom);
    lat      = 1;
    ready_ok = 1'b1;
    @(negedge clk);
    while (done !== 1'b1 && lat < 100) begin
      if (ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = frame;
    check_output("ready low while busy", FW'(ready_ok), FW'(1));
    check_output("ready at done", FW'(ready), FW'(1));
    @(negedge clk);
    check_output("done single pulse", FW'(done), FW'(0));
    check_output("frame holds", frame, got);
  endtask

  initial begin
    int            lat;
    int            k;
    int            first;
    int            second;
    int            seen;
    logic [FW-1:0] got;
    logic [7:0]    m;
    logic [VAL_W-1:0] v;

    vecs[0] = '{mode: 8'h00, value: 16'd0,     row0: "Original Picture", row1: "Val:___________0"};
    vecs[1] = '{mode: 8'h01, value: 16'd65535, row0: "Transmission Map", row1: "Val:_______65535"};
    vecs[2] = '{mode: 8'h05, value: 16'd1234,  row0: "I love DCLab!___", row1: "Val:________1234"};
    vecs[3] = '{mode: 8'hFF, value: 16'd7,     row0: "________________", row1: "Val:___________7"};
    vecs[4] = '{mode: 8'h02, value: 16'd10000, row0: "Dehazed Picture_", row1: "Val:_______10000"};
    vecs[5] = '{mode: 8'hFE, value: 16'd100,   row0: "I love DCLab!___", row1: "Val:_________100"};

    rst   = 1'b1;
    valid = 1'b0;
    mode  = 8'h00;
    value = '0;
    repeat (3) @(negedge clk);
    check_output("reset frame blank", frame, {(ROWS*COLS){BLANK}});
    check_output("reset ready", FW'(ready), FW'(1));
    check_output("reset done", FW'(done), FW'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].mode, vecs[i].value, lat, got);
      check_output($sformatf("table %0d latency", i), FW'(lat), FW'(LAT));
      check_output($sformatf("table %0d frame", i), got,
                   {row_from_text(vecs[i].row1), row_from_text(vecs[i].row0)});
    end

    // Held-high valid: requests during the busy window are dropped, next accept right at done.
    mode   = 8'hFF;
    value  = 16'd7;
    valid  = 1'b1;
    @(posedge clk);
    #1;
    mode   = 8'h01;
    value  = 16'd500;
    k      = 1;
    first  = -1;
    second = -1;
    while (k < 100 && second < 0) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) begin
          first = k;
          check_output("b2b first frame", frame, model_frame(8'hFF, 16'd7));
        end else begin
          second = k;
          check_output("b2b second frame", frame, model_frame(8'h01, 16'd500));
        end
      end
      if (k == 19) valid = 1'b0;
      @(posedge clk);
      k++;
    end
    valid = 1'b0;
    check_output("b2b first latency", FW'(first), FW'(LAT));
    check_output("b2b second latency", FW'(second), FW'(2*LAT));

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    mode  = 8'h02;
    value = 16'd999;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("abort frame blank", frame, {(ROWS*COLS){BLANK}});
    check_output("abort ready", FW'(ready), FW'(1));
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check_output("abort no done", FW'(seen), FW'(0));
    check_output("abort ready after", FW'(ready), FW'(1));

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 4))
        0: m = 8'h00;
        1: m = 8'h01;
        2: m = 8'h02;
        3: m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: v = '0;
        1: v = '1;
        default: v = VAL_W'($urandom);
      endcase
      apply_stimulus(m, v, lat, got);
      check_output($sformatf("rand %0d latency", i), FW'(lat), FW'(LAT));
      check_output($sformatf("rand %0d frame m=%0h v=%0d", i, m, v), got, model_frame(m, v));
    end

`ifdef LCD_SCROLL_EN
    apply_stimulus(8'h00, 16'd42, lat, got);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("scroll col0", FW'(frame[7:0]), FW'(8'h72));
    check_output("scroll col15", FW'(frame[15*8 +: 8]), FW'(8'h4F));
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_output("scroll wrap", frame, model_frame(8'h00, 16'd42));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
